// File: rtl/mem_stage_pkg.sv
// Shared widths, memory-op encoding, FSM states and the WB bundle layout for mem_stage.
package mem_stage_pkg;

  localparam int unsigned XLEN         = 32;
  localparam int unsigned REG_AW       = 5;
  localparam int unsigned CSR_AW       = 12;
  localparam int unsigned EXC_CW       = 4;
  localparam int unsigned MEM_OP_WIDTH = 3;

  // One-hot bit positions inside mem_opcode
  localparam int unsigned MEM_OP_BYTE = 0;
  localparam int unsigned MEM_OP_HALF = 1;
  localparam int unsigned MEM_OP_WORD = 2;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_DRAIN = 1'b1
  } mem_state_e;

  // Registered MEM->WB payload
  typedef struct packed {
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   instruction;
    logic              rd_write;
    logic [REG_AW-1:0] rd_addr;
    logic [XLEN-1:0]   rd_wdata;
    logic              csr_write;
    logic              csr_set;
    logic              csr_clear;
    logic              csr_read;
    logic [XLEN-1:0]   csr_info;
    logic [CSR_AW-1:0] csr_addr;
    logic              mret;
    logic              exc_pending;
    logic [EXC_CW-1:0] exc_code;
    logic [XLEN-1:0]   exc_tval;
    logic              exc_interrupt;
  } wb_bundle_t;

endpackage

// File: rtl/mem_stage_load_align.sv
// Load data alignment and sign/zero extension.
//   opcode    : one-hot BYTE/HALF/WORD
//   byte_addr : byte offset within the word
//   unsign    : zero-extend instead of sign-extend
//   rdata     : raw 32-bit word from data RAM
//   aligned_c : combinational aligned result
module mem_stage_load_align
  import mem_stage_pkg::*;
(
  input  logic [MEM_OP_WIDTH-1:0] opcode,
  input  logic [1:0]              byte_addr,
  input  logic                    unsign,
  input  logic [XLEN-1:0]         rdata,
  output logic [XLEN-1:0]         aligned_c
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    ld_byte   = rdata[{byte_addr, 3'b000} +: 8];
    ld_half   = rdata[{byte_addr[1], 4'b0000} +: 16];
    aligned_c = '0;
    if (opcode[MEM_OP_BYTE]) begin
      aligned_c = {{(XLEN-8){~unsign & ld_byte[7]}}, ld_byte};
    end else if (opcode[MEM_OP_HALF]) begin
      aligned_c = {{(XLEN-16){~unsign & ld_half[15]}}, ld_half};
    end else if (opcode[MEM_OP_WORD]) begin
      aligned_c = rdata;
    end
  end

endmodule

// File: rtl/mem_stage.sv
// RV32 memory stage: waits for load data, aligns it, forwards rd to ID and
// registers the WB bundle. CSR/trap fields pass through.
//   clk, rst_b         : clock, async active-low reset
//   mem_pipe_*         : EX->MEM bundle in, ready/flush back to EX
//   dram_rvalid/rdata  : in-order read responses for issued loads
//   wb_pipe_*          : registered MEM->WB bundle, ready/flush from WB
//   mem_rd_*           : combinational rd forward to ID (pending = stall)
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter bit SUPPORT_ZICSR = 1'b1,
  parameter bit SUPPORT_TRAP  = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst_b,
  output logic                    mem_pipe_ready,
  output logic                    mem_pipe_flush,
  input  logic                    mem_pipe_valid,
  input  logic [XLEN-1:0]         mem_pipe_pc,
  input  logic [XLEN-1:0]         mem_pipe_instruction,
  input  logic [MEM_OP_WIDTH-1:0] mem_pipe_mem_opcode,
  input  logic                    mem_pipe_mem_read,
  input  logic [1:0]              mem_pipe_mem_byte_addr,
  input  logic                    mem_pipe_unsign,
  input  logic                    mem_pipe_rd_write,
  input  logic [REG_AW-1:0]       mem_pipe_rd_addr,
  input  logic [XLEN-1:0]         mem_pipe_alu_result,
  input  logic                    mem_pipe_csr_write,
  input  logic                    mem_pipe_csr_set,
  input  logic                    mem_pipe_csr_clear,
  input  logic                    mem_pipe_csr_read,
  input  logic [XLEN-1:0]         mem_pipe_csr_info,
  input  logic [CSR_AW-1:0]       mem_pipe_csr_addr,
  input  logic                    mem_pipe_mret,
  input  logic                    mem_pipe_exc_pending,
  input  logic                    mem_pipe_exc_interrupt,
  input  logic [EXC_CW-1:0]       mem_pipe_exc_code,
  input  logic [XLEN-1:0]         mem_pipe_exc_tval,
  input  logic                    dram_rvalid,
  input  logic [XLEN-1:0]         dram_rdata,
  input  logic                    wb_pipe_ready,
  input  logic                    wb_pipe_flush,
  output logic                    wb_pipe_valid,
  output logic [XLEN-1:0]         wb_pipe_pc,
  output logic [XLEN-1:0]         wb_pipe_instruction,
  output logic                    wb_pipe_rd_write,
  output logic [REG_AW-1:0]       wb_pipe_rd_addr,
  output logic [XLEN-1:0]         wb_pipe_rd_wdata,
  output logic                    wb_pipe_csr_write,
  output logic                    wb_pipe_csr_set,
  output logic                    wb_pipe_csr_clear,
  output logic                    wb_pipe_csr_read,
  output logic [XLEN-1:0]         wb_pipe_csr_info,
  output logic [CSR_AW-1:0]       wb_pipe_csr_addr,
  output logic                    wb_pipe_mret,
  output logic                    wb_pipe_exc_pending,
  output logic [EXC_CW-1:0]       wb_pipe_exc_code,
  output logic [XLEN-1:0]         wb_pipe_exc_tval,
  output logic                    wb_pipe_exc_interrupt,
  output logic                    mem_rd_write,
  output logic [REG_AW-1:0]       mem_rd_addr,
  output logic [XLEN-1:0]         mem_rd_wdata,
  output logic                    mem_rd_pending
);

  mem_state_e      state_q, state_d;
  logic            buf_valid_q;
  logic [XLEN-1:0] buf_data_q;
  logic            wb_valid_q;
  wb_bundle_t      wb_q, wb_d;

  logic            running, mem_valid, data_ok, mem_req, advance, buf_capture;
  logic [XLEN-1:0] ld_data, aligned, rd_wdata;

  // Handshake; DRAIN also blocks mem_req so a stale response is never consumed
  assign running        = (state_q == ST_RUN);
  assign mem_valid      = mem_pipe_valid & ~wb_pipe_flush;
  assign data_ok        = ~mem_pipe_mem_read | buf_valid_q | dram_rvalid;
  assign mem_req        = running & mem_valid & data_ok;
  assign advance        = wb_pipe_ready & mem_req;
  assign mem_pipe_ready = running & (~mem_valid | advance);
  assign mem_pipe_flush = (mem_pipe_valid & mem_pipe_exc_pending) | wb_pipe_flush;

  assign buf_capture = running & dram_rvalid & mem_valid & mem_pipe_mem_read &
                       ~buf_valid_q & ~wb_pipe_ready;

  // Buffered word has priority over the live response
  assign ld_data  = buf_valid_q ? buf_data_q : dram_rdata;
  assign rd_wdata = mem_pipe_mem_read ? aligned : mem_pipe_alu_result;

  mem_stage_load_align u_load_align (
    .opcode    (mem_pipe_mem_opcode),
    .byte_addr (mem_pipe_mem_byte_addr),
    .unsign    (mem_pipe_unsign),
    .rdata     (ld_data),
    .aligned_c (aligned)
  );

  // Forward to ID
  assign mem_rd_write   = mem_pipe_valid & mem_pipe_rd_write;
  assign mem_rd_addr    = mem_pipe_rd_addr;
  assign mem_rd_wdata   = rd_wdata;
  assign mem_rd_pending = mem_rd_write & mem_pipe_mem_read & ~data_ok;

  // Next state: a flushed load with no data yet leaves a response in flight to drop
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN: begin
        if (wb_pipe_flush & mem_pipe_valid & mem_pipe_mem_read &
            ~buf_valid_q & ~dram_rvalid) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (dram_rvalid) begin
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // One-entry response buffer for when WB back-pressures
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      buf_valid_q <= 1'b0;
      buf_data_q  <= '0;
    end else if (advance | wb_pipe_flush) begin
      buf_valid_q <= 1'b0;
    end else if (buf_capture) begin
      buf_valid_q <= 1'b1;
      buf_data_q  <= dram_rdata;
    end
  end

  // WB bundle assembly, optional CSR/trap fields tied off when unsupported
  always_comb begin
    wb_d               = '0;
    wb_d.pc            = mem_pipe_pc;
    wb_d.instruction   = mem_pipe_instruction;
    wb_d.rd_write      = mem_pipe_rd_write;
    wb_d.rd_addr       = mem_pipe_rd_addr;
    wb_d.rd_wdata      = rd_wdata;
    if (SUPPORT_ZICSR) begin
      wb_d.csr_write   = mem_pipe_csr_write;
      wb_d.csr_set     = mem_pipe_csr_set;
      wb_d.csr_clear   = mem_pipe_csr_clear;
      wb_d.csr_read    = mem_pipe_csr_read;
      wb_d.csr_info    = mem_pipe_csr_info;
      wb_d.csr_addr    = mem_pipe_csr_addr;
    end
    if (SUPPORT_TRAP) begin
      wb_d.mret          = mem_pipe_mret;
      wb_d.exc_pending   = mem_pipe_exc_pending;
      wb_d.exc_code      = mem_pipe_exc_code;
      wb_d.exc_tval      = mem_pipe_exc_tval;
      wb_d.exc_interrupt = mem_pipe_exc_interrupt;
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      wb_valid_q <= 1'b0;
      wb_q       <= '0;
    end else if (wb_pipe_ready) begin
      wb_valid_q <= mem_req;
      if (mem_req) begin
        wb_q <= wb_d;
      end
    end
  end

  assign wb_pipe_valid         = wb_valid_q;
  assign wb_pipe_pc            = wb_q.pc;
  assign wb_pipe_instruction   = wb_q.instruction;
  assign wb_pipe_rd_write      = wb_q.rd_write;
  assign wb_pipe_rd_addr       = wb_q.rd_addr;
  assign wb_pipe_rd_wdata      = wb_q.rd_wdata;
  assign wb_pipe_csr_write     = wb_q.csr_write;
  assign wb_pipe_csr_set       = wb_q.csr_set;
  assign wb_pipe_csr_clear     = wb_q.csr_clear;
  assign wb_pipe_csr_read      = wb_q.csr_read;
  assign wb_pipe_csr_info      = wb_q.csr_info;
  assign wb_pipe_csr_addr      = wb_q.csr_addr;
  assign wb_pipe_mret          = wb_q.mret;
  assign wb_pipe_exc_pending   = wb_q.exc_pending;
  assign wb_pipe_exc_code      = wb_q.exc_code;
  assign wb_pipe_exc_tval      = wb_q.exc_tval;
  assign wb_pipe_exc_interrupt = wb_q.exc_interrupt;

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: directed scenarios plus randomized traffic.
module tb_mem_stage;
  import mem_stage_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_b;
  logic        mem_pipe_ready, mem_pipe_flush, mem_pipe_valid;
  logic [31:0] mem_pipe_pc, mem_pipe_instruction;
  logic [2:0]  mem_pipe_mem_opcode;
  logic        mem_pipe_mem_read, mem_pipe_unsign, mem_pipe_rd_write;
  logic [1:0]  mem_pipe_mem_byte_addr;
  logic [4:0]  mem_pipe_rd_addr;
  logic [31:0] mem_pipe_alu_result;
  logic        mem_pipe_csr_write, mem_pipe_csr_set, mem_pipe_csr_clear, mem_pipe_csr_read;
  logic [31:0] mem_pipe_csr_info;
  logic [11:0] mem_pipe_csr_addr;
  logic        mem_pipe_mret, mem_pipe_exc_pending, mem_pipe_exc_interrupt;
  logic [3:0]  mem_pipe_exc_code;
  logic [31:0] mem_pipe_exc_tval;
  logic        dram_rvalid;
  logic [31:0] dram_rdata;
  logic        wb_pipe_ready, wb_pipe_flush, wb_pipe_valid;
  logic [31:0] wb_pipe_pc, wb_pipe_instruction, wb_pipe_rd_wdata;
  logic        wb_pipe_rd_write;
  logic [4:0]  wb_pipe_rd_addr;
  logic        wb_pipe_csr_write, wb_pipe_csr_set, wb_pipe_csr_clear, wb_pipe_csr_read;
  logic [31:0] wb_pipe_csr_info;
  logic [11:0] wb_pipe_csr_addr;
  logic        wb_pipe_mret, wb_pipe_exc_pending, wb_pipe_exc_interrupt;
  logic [3:0]  wb_pipe_exc_code;
  logic [31:0] wb_pipe_exc_tval;
  logic        mem_rd_write, mem_rd_pending;
  logic [4:0]  mem_rd_addr;
  logic [31:0] mem_rd_wdata;

  mem_stage dut (
    .clk(clk), .rst_b(rst_b),
    .mem_pipe_ready(mem_pipe_ready), .mem_pipe_flush(mem_pipe_flush),
    .mem_pipe_valid(mem_pipe_valid), .mem_pipe_pc(mem_pipe_pc),
    .mem_pipe_instruction(mem_pipe_instruction), .mem_pipe_mem_opcode(mem_pipe_mem_opcode),
    .mem_pipe_mem_read(mem_pipe_mem_read), .mem_pipe_mem_byte_addr(mem_pipe_mem_byte_addr),
    .mem_pipe_unsign(mem_pipe_unsign), .mem_pipe_rd_write(mem_pipe_rd_write),
    .mem_pipe_rd_addr(mem_pipe_rd_addr), .mem_pipe_alu_result(mem_pipe_alu_result),
    .mem_pipe_csr_write(mem_pipe_csr_write), .mem_pipe_csr_set(mem_pipe_csr_set),
    .mem_pipe_csr_clear(mem_pipe_csr_clear), .mem_pipe_csr_read(mem_pipe_csr_read),
    .mem_pipe_csr_info(mem_pipe_csr_info), .mem_pipe_csr_addr(mem_pipe_csr_addr),
    .mem_pipe_mret(mem_pipe_mret), .mem_pipe_exc_pending(mem_pipe_exc_pending),
    .mem_pipe_exc_interrupt(mem_pipe_exc_interrupt), .mem_pipe_exc_code(mem_pipe_exc_code),
    .mem_pipe_exc_tval(mem_pipe_exc_tval),
    .dram_rvalid(dram_rvalid), .dram_rdata(dram_rdata),
    .wb_pipe_ready(wb_pipe_ready), .wb_pipe_flush(wb_pipe_flush),
    .wb_pipe_valid(wb_pipe_valid), .wb_pipe_pc(wb_pipe_pc),
    .wb_pipe_instruction(wb_pipe_instruction), .wb_pipe_rd_write(wb_pipe_rd_write),
    .wb_pipe_rd_addr(wb_pipe_rd_addr), .wb_pipe_rd_wdata(wb_pipe_rd_wdata),
    .wb_pipe_csr_write(wb_pipe_csr_write), .wb_pipe_csr_set(wb_pipe_csr_set),
    .wb_pipe_csr_clear(wb_pipe_csr_clear), .wb_pipe_csr_read(wb_pipe_csr_read),
    .wb_pipe_csr_info(wb_pipe_csr_info), .wb_pipe_csr_addr(wb_pipe_csr_addr),
    .wb_pipe_mret(wb_pipe_mret), .wb_pipe_exc_pending(wb_pipe_exc_pending),
    .wb_pipe_exc_code(wb_pipe_exc_code), .wb_pipe_exc_tval(wb_pipe_exc_tval),
    .wb_pipe_exc_interrupt(wb_pipe_exc_interrupt),
    .mem_rd_write(mem_rd_write), .mem_rd_addr(mem_rd_addr),
    .mem_rd_wdata(mem_rd_wdata), .mem_rd_pending(mem_rd_pending)
  );

  typedef struct {
    logic [31:0] pc;
    logic [2:0]  op;
    logic        rd;
    logic [1:0]  ba;
    logic        uns;
    logic        rdw;
    logic [4:0]  rda;
    logic [31:0] alu;
    logic [31:0] rdata;
    int          lat;
    logic        csrw;
    logic [31:0] csr_info;
    logic        exc;
    logic [3:0]  code;
    logic [31:0] tval;
  } txn_t;

  typedef struct packed {
    logic [31:0] pc;
    logic        rdw;
    logic [4:0]  rda;
    logic [31:0] wdata;
    logic        csrw;
    logic [31:0] csr_info;
    logic        exc;
    logic [3:0]  code;
    logic [31:0] tval;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  bit   rand_ready = 1'b0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  // Reference load semantics expressed with shifts/masks on the raw word
  function automatic logic [31:0] ref_load(input logic [2:0] op, input logic [1:0] ba,
                                           input logic uns, input logic [31:0] d);
    logic [31:0] v;
    if (op == 3'b001) begin
      v = (d >> (8 * ba)) & 32'h0000_00FF;
      if (!uns && v >= 32'd128) v = v + 32'hFFFF_FF00;
    end else if (op == 3'b010) begin
      v = (d >> (16 * ba[1])) & 32'h0000_FFFF;
      if (!uns && v >= 32'd32768) v = v + 32'hFFFF_0000;
    end else begin
      v = d;
    end
    return v;
  endfunction

  function automatic txn_t mk_alu(input logic [31:0] pc, input logic [31:0] alu);
    txn_t t;
    t = '{pc: pc, op: 3'b100, rd: 1'b0, ba: 2'd0, uns: 1'b0, rdw: 1'b1, rda: 5'd3,
          alu: alu, rdata: 32'h0, lat: 0, csrw: 1'b0, csr_info: 32'h0,
          exc: 1'b0, code: 4'd0, tval: 32'h0};
    return t;
  endfunction

  function automatic txn_t mk_load(input logic [31:0] pc, input logic [2:0] op, input logic [1:0] ba,
                                   input logic uns, input logic [31:0] d, input int lat);
    txn_t t;
    t = mk_alu(pc, 32'hA5A5_0000 ^ pc);
    t.op = op; t.rd = 1'b1; t.ba = ba; t.uns = uns; t.rdata = d; t.lat = lat; t.rda = 5'd7;
    return t;
  endfunction

  function automatic txn_t rand_txn(input logic [31:0] pc);
    txn_t t;
    int   k;
    t = mk_alu(pc, $urandom);
    t.rdw = 1'($urandom_range(0, 1));
    t.rda = 5'($urandom);
    t.csrw = 1'($urandom_range(0, 1));
    t.csr_info = $urandom;
    if ($urandom_range(0, 7) == 0) begin
      t.exc = 1'b1; t.code = 4'($urandom); t.tval = $urandom;
    end else if ($urandom_range(0, 1) == 1) begin
      k = $urandom_range(0, 2);
      t.rd = 1'b1;
      t.uns = 1'($urandom_range(0, 1));
      t.rdata = $urandom;
      t.lat = $urandom_range(0, 3);
      if (k == 0) begin t.op = 3'b001; t.ba = 2'($urandom); end
      else if (k == 1) begin t.op = 3'b010; t.ba = {1'($urandom), 1'b0}; end
      else begin t.op = 3'b100; t.ba = 2'd0; end
    end
    return t;
  endfunction

  task automatic apply(input txn_t t);
    mem_pipe_valid         = 1'b1;
    mem_pipe_pc            = t.pc;
    mem_pipe_instruction   = ~t.pc;
    mem_pipe_mem_opcode    = t.op;
    mem_pipe_mem_read      = t.rd;
    mem_pipe_mem_byte_addr = t.ba;
    mem_pipe_unsign        = t.uns;
    mem_pipe_rd_write      = t.rdw;
    mem_pipe_rd_addr       = t.rda;
    mem_pipe_alu_result    = t.alu;
    mem_pipe_csr_write     = t.csrw;
    mem_pipe_csr_info      = t.csr_info;
    mem_pipe_exc_pending   = t.exc;
    mem_pipe_exc_code      = t.code;
    mem_pipe_exc_tval      = t.tval;
  endtask

  // Present one instruction until accepted; the accept edge is the next posedge
  task automatic run_txn(input txn_t t, output int waitc, output int pendc);
    exp_t e;
    bit   sent;
    bit   done;
    waitc = 0; pendc = 0; sent = 1'b0; done = 1'b0;
    e.pc = t.pc; e.rdw = t.rdw; e.rda = t.rda;
    e.wdata = t.rd ? ref_load(t.op, t.ba, t.uns, t.rdata) : t.alu;
    e.csrw = t.csrw; e.csr_info = t.csr_info;
    e.exc = t.exc; e.code = t.code; e.tval = t.tval;
    @(posedge clk); #1;
    apply(t);
    sb.push_back(e);
    for (int cyc = 0; cyc < 60 && !done; cyc++) begin
      dram_rvalid = t.rd && !sent && (cyc == t.lat);
      dram_rdata  = dram_rvalid ? t.rdata : $urandom;
      if (dram_rvalid) sent = 1'b1;
      @(negedge clk);
      if (cyc == 0 && t.exc) chk("exc_flush_same_cycle", 64'(mem_pipe_flush), 64'd1);
      if (mem_rd_pending) pendc++;
      if (mem_pipe_ready) done = 1'b1;
      else begin
        waitc++;
        @(posedge clk); #1;
      end
    end
    if (!done) chk("accept_timeout", 64'(mem_pipe_ready), 64'd1);
  endtask

  task automatic idle();
    @(posedge clk); #1;
    mem_pipe_valid = 1'b0;
    dram_rvalid    = 1'b0;
  endtask

  // WB acceptance model: ready toggles randomly during the random phase
  always @(posedge clk) begin
    if (rand_ready) begin
      #1 wb_pipe_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor: every bundle WB takes must match the oldest expected entry
  always @(negedge clk) begin
    exp_t got, e;
    if (rst_b && wb_pipe_valid && wb_pipe_ready) begin
      got = '{pc: wb_pipe_pc, rdw: wb_pipe_rd_write, rda: wb_pipe_rd_addr, wdata: wb_pipe_rd_wdata,
              csrw: wb_pipe_csr_write, csr_info: wb_pipe_csr_info, exc: wb_pipe_exc_pending,
              code: wb_pipe_exc_code, tval: wb_pipe_exc_tval};
      n_checks++;
      if (sb.size() == 0) begin
        $display("FAIL wb_unexpected: got pc=%h wdata=%h with nothing expected", got.pc, got.wdata);
      end else begin
        e = sb.pop_front();
        if (got === e) n_pass++;
        else $display("FAIL wb_bundle pc=%h: got wdata=%h rd=%b/%0d csr=%b/%h exc=%b/%0d/%h, expected wdata=%h rd=%b/%0d csr=%b/%h exc=%b/%0d/%h",
                      e.pc, got.wdata, got.rdw, got.rda, got.csrw, got.csr_info, got.exc, got.code, got.tval,
                      e.wdata, e.rdw, e.rda, e.csrw, e.csr_info, e.exc, e.code, e.tval);
      end
    end
  end

  initial begin
    txn_t t;
    int   w, p;
    rst_b = 1'b0; wb_pipe_ready = 1'b1; wb_pipe_flush = 1'b0;
    dram_rvalid = 1'b0; dram_rdata = '0;
    t = mk_alu(32'h0, 32'h0); apply(t); mem_pipe_valid = 1'b0;
    mem_pipe_csr_set = 1'b0; mem_pipe_csr_clear = 1'b0; mem_pipe_csr_read = 1'b0;
    mem_pipe_csr_addr = 12'h300; mem_pipe_mret = 1'b0; mem_pipe_exc_interrupt = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_wb_valid", 64'(wb_pipe_valid), 64'd0);
    chk("reset_ready", 64'(mem_pipe_ready), 64'd1);
    @(posedge clk); #1 rst_b = 1'b1;

    // LW with one-cycle response latency
    run_txn(mk_load(32'h100, 3'b100, 2'd0, 1'b0, 32'hDEADBEEF, 1), w, p);
    chk("lw_ready_low_cycles", 64'(w), 64'd1);
    chk("lw_pending_cycles", 64'(p), 64'd1);
    idle();
    chk("lw_wb_valid", 64'(wb_pipe_valid), 64'd1);
    chk("lw_wb_wdata", 64'(wb_pipe_rd_wdata), 64'hDEADBEEF);

    // Sub-word alignment on 0x80018000
    run_txn(mk_load(32'h104, 3'b001, 2'd1, 1'b0, 32'h80018000, 0), w, p);
    run_txn(mk_load(32'h108, 3'b001, 2'd1, 1'b1, 32'h80018000, 0), w, p);
    run_txn(mk_load(32'h10C, 3'b010, 2'd2, 1'b0, 32'h80018000, 0), w, p);
    run_txn(mk_load(32'h110, 3'b010, 2'd0, 1'b1, 32'h80018000, 0), w, p);
    chk("zero_latency_ready", 64'(w), 64'd0);
    idle(); idle();

    // Response buffered while WB stalls; later cycles carry junk on dram_rdata
    wb_pipe_ready = 1'b0;
    fork
      run_txn(mk_load(32'h114, 3'b100, 2'd0, 1'b0, 32'h12345678, 0), w, p);
      begin repeat (3) @(posedge clk); #1 wb_pipe_ready = 1'b1; end
    join
    chk("buf_no_pending", 64'(p), 64'd0);
    idle(); idle();

    // Flush while a load waits: response four cycles later must be dropped
    @(posedge clk); #1;
    apply(mk_load(32'h118, 3'b100, 2'd0, 1'b0, 32'hCAFEF00D, 0));
    wb_pipe_flush = 1'b1;
    @(negedge clk);
    chk("flush_passthrough", 64'(mem_pipe_flush), 64'd1);
    @(posedge clk); #1;
    wb_pipe_flush = 1'b0; mem_pipe_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) begin @(posedge clk); #1; end
      dram_rvalid = (i == 3); dram_rdata = 32'hCAFEF00D;
      @(negedge clk);
      chk("drain_ready_low", 64'(mem_pipe_ready), 64'd0);
      chk("drain_wb_valid", 64'(wb_pipe_valid), 64'd0);
    end
    @(posedge clk); #1 dram_rvalid = 1'b0;
    @(negedge clk);
    chk("drain_exit_ready", 64'(mem_pipe_ready), 64'd1);
    chk("drain_no_wb", 64'(wb_pipe_valid), 64'd0);

    // Exception fields travel to WB
    t = mk_alu(32'h11C, 32'h0); t.exc = 1'b1; t.code = 4'd4; t.tval = 32'h1002;
    run_txn(t, w, p);
    idle();
    chk("exc_wb_pending", 64'(wb_pipe_exc_pending), 64'd1);
    chk("exc_wb_code", 64'(wb_pipe_exc_code), 64'd4);
    chk("exc_wb_tval", 64'(wb_pipe_exc_tval), 64'h1002);

    // Reset while a stalled load sits with its data buffered
    run_txn(mk_alu(32'h120, 32'h7), w, p);
    @(posedge clk); #1;
    wb_pipe_ready = 1'b0;
    apply(mk_load(32'h124, 3'b100, 2'd0, 1'b0, 32'h0BADF00D, 0));
    dram_rvalid = 1'b1; dram_rdata = 32'h0BADF00D;
    @(posedge clk); #1 dram_rvalid = 1'b0;
    @(negedge clk);
    chk("buffered_not_pending", 64'(mem_rd_pending), 64'd0);
    chk("stalled_wb_valid", 64'(wb_pipe_valid), 64'd1);
    @(posedge clk); #1 rst_b = 1'b0;
    #1;
    chk("rst_wb_valid", 64'(wb_pipe_valid), 64'd0);
    chk("rst_buf_empty", 64'(mem_rd_pending), 64'd1);
    sb.delete();
    @(posedge clk); #1;
    rst_b = 1'b1; mem_pipe_valid = 1'b0; wb_pipe_ready = 1'b1;
    run_txn(mk_alu(32'h128, 32'h5), w, p);
    chk("post_rst_ready", 64'(w), 64'd0);
    idle();
    chk("post_rst_wb_valid", 64'(wb_pipe_valid), 64'd1);
    chk("post_rst_wdata", 64'(wb_pipe_rd_wdata), 64'h5);

    // Randomized traffic with random WB back-pressure
    rand_ready = 1'b1;
    for (int n = 0; n < 150; n++) begin
      run_txn(rand_txn(32'h1000 + 32'(n * 4)), w, p);
    end
    idle();
    rand_ready = 1'b0;
    #2 wb_pipe_ready = 1'b1;
    for (int n = 0; n < 20 && sb.size() != 0; n++) @(posedge clk);
    repeat (2) @(posedge clk);
    chk("scoreboard_empty", 64'(sb.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
